baccarat_fsm: RTL and testbench

- Sequencing controller for the baccarat datapath. Drives the six card-load strobes in dealing order.
- Applies the third-card rules for player and banker using the datapath's live scores and player third card.
- Raises the win lights when the round ends.
- Moore FSM clocked by slow_clock, so one card is dealt per slow_clock cycle.

---
 rtl/baccarat_pkg.sv | 29 ++
 rtl/baccarat_fsm_banker_draw_rule.sv | 23 ++
 rtl/baccarat_fsm.sv | 110 +++++++++++
 tb/tb_baccarat_fsm.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared types and rule constants for the baccarat controller and datapath.
// Optional build macro used by baccarat_fsm: ROUND_TALLY_EN.
package baccarat_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        P1   = 4'd1,
        D1   = 4'd2,
        P2   = 4'd3,
        D2   = 4'd4,
        CHK  = 4'd5,
        P3   = 4'd6,
        BCHK = 4'd7,
        D3   = 4'd8,
        DONE = 4'd9
    } state_t;

    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;

    // Ten and the face cards (and the unused codes 0, 14, 15) score zero.
    function automatic logic [3:0] card_value(input logic [3:0] card);
        if (card >= 4'd1 && card <= 4'd9)
            return card;
        else
            return 4'd0;
    endfunction

endpackage

// File: rtl/baccarat_fsm_banker_draw_rule.sv
// Banker third-card rule: decides whether the banker draws, given the
// banker's score and the game value of the player's third card.
import baccarat_pkg::*;

module banker_draw_rule (
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3_value,
    output logic       draw
);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (pcard3_value != 4'd8);
            4'd4:             draw = (pcard3_value >= 4'd2) && (pcard3_value <= 4'd7);
            4'd5:             draw = (pcard3_value >= 4'd4) && (pcard3_value <= 4'd7);
            4'd6:             draw = (pcard3_value >= 4'd6) && (pcard3_value <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_fsm.sv
// Moore sequencing controller for the baccarat datapath, one card per slow_clock.
// Optional build macro ROUND_TALLY_EN adds saturating win/loss/tie tallies.
import baccarat_pkg::*;

module baccarat_fsm (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
`ifdef ROUND_TALLY_EN
    input  logic       tally_clr,
    output logic [7:0] player_wins,
    output logic [7:0] dealer_wins,
    output logic [7:0] ties,
`endif
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    state_t state;
    state_t next_state;
    logic   banker_draws;

    banker_draw_rule u_banker_draw_rule (
        .dscore       (dscore),
        .pcard3_value (card_value(pcard3)),
        .draw         (banker_draws)
    );

    always_ff @(posedge slow_clock) begin
        if (resetb)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: next_state = P1;
            P1:   next_state = D1;
            D1:   next_state = P2;
            P2:   next_state = D2;
            D2:   next_state = CHK;
            CHK: begin
                if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN)
                    next_state = DONE;
                else if (pscore < PLAYER_STAND_MIN)
                    next_state = P3;
                else if (dscore < PLAYER_STAND_MIN)
                    next_state = D3;
                else
                    next_state = DONE;
            end
            P3:   next_state = BCHK;
            BCHK: next_state = banker_draws ? D3 : DONE;
            D3:   next_state = DONE;
            DONE: next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes decode purely from state; lights only look at the scores in DONE.
    always_comb begin
        load_pcard1      = (state == P1);
        load_dcard1      = (state == D1);
        load_pcard2      = (state == P2);
        load_dcard2      = (state == D2);
        load_pcard3      = (state == P3);
        load_dcard3      = (state == D3);
        player_win_light = (state == DONE) && (pscore >= dscore);
        dealer_win_light = (state == DONE) && (dscore >= pscore);
    end

`ifdef ROUND_TALLY_EN
    logic in_done_q;

    always_ff @(posedge slow_clock) begin
        if (resetb)
            in_done_q <= 1'b0;
        else
            in_done_q <= (state == DONE);
    end

    // Count on the first DONE cycle, once the final card has reached the scores.
    always_ff @(posedge slow_clock) begin
        if (tally_clr) begin
            player_wins <= 8'd0;
            dealer_wins <= 8'd0;
            ties        <= 8'd0;
        end else if (state == DONE && !in_done_q) begin
            if (player_win_light && dealer_win_light) begin
                if (ties != 8'hFF) ties <= ties + 8'd1;
            end else if (player_win_light) begin
                if (player_wins != 8'hFF) player_wins <= player_wins + 8'd1;
            end else if (dealer_win_light) begin
                if (dealer_wins != 8'hFF) dealer_wins <= dealer_wins + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_baccarat_fsm.sv
// Directed self-checking bench for baccarat_fsm; tally checks only when
// ROUND_TALLY_EN is defined.
module tb_baccarat_fsm;

    logic       slow_clock;
    logic       resetb;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;
`ifdef ROUND_TALLY_EN
    logic       tally_clr;
    logic [7:0] player_wins, dealer_wins, ties;
`endif

    int vectors;
    int miscompares;

    baccarat_fsm dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
`ifdef ROUND_TALLY_EN
        .tally_clr        (tally_clr),
        .player_wins      (player_wins),
        .dealer_wins      (dealer_wins),
        .ties             (ties),
`endif
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light)
    );

    initial begin
        slow_clock = 1'b0;
        forever #5 slow_clock = ~slow_clock;
    end

    // Output vector: {P1, D1, P2, D2, P3, D3 strobes, player light, dealer light}.
    function automatic logic [7:0] obs();
        return {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                load_pcard3, load_dcard3, player_win_light, dealer_win_light};
    endfunction

    function automatic logic [7:0] deal_pattern(input int i);
        logic [7:0] first;
        first = 8'b1000_0000;
        return first >> i;
    endfunction

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic start_round();
        resetb = 1'b1;
        tick();
        resetb = 1'b0;
    endtask

    task automatic test_reset();
        resetb = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs() !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL reset_hold%0d: got %b expected %b", i, obs(), 8'h00);
            end
        end
        resetb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (obs() !== deal_pattern(i)) begin
                miscompares++;
                $display("[TB] FAIL reset_deal%0d: got %b expected %b", i, obs(), deal_pattern(i));
            end
        end
    endtask

    task automatic test_natural();
        start_round();
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (obs() !== deal_pattern(i)) begin
                miscompares++;
                $display("[TB] FAIL natural_deal%0d: got %b expected %b", i, obs(), deal_pattern(i));
            end
        end
        pscore = 4'd8;
        dscore = 4'd3;
        tick();
        vectors++;
        if (obs() !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL natural_chk: got %b expected %b", obs(), 8'h00);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs() !== 8'b0000_0010) begin
                miscompares++;
                $display("[TB] FAIL natural_done%0d: got %b expected %b", i, obs(), 8'b0000_0010);
            end
        end
    endtask

    task automatic test_player_stand();
        start_round();
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (obs() !== deal_pattern(i)) begin
                miscompares++;
                $display("[TB] FAIL stand_deal%0d: got %b expected %b", i, obs(), deal_pattern(i));
            end
        end
        pscore = 4'd7;
        dscore = 4'd4;
        tick();
        vectors++;
        if (obs() !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL stand_chk: got %b expected %b", obs(), 8'h00);
        end
        tick();
        vectors++;
        if (obs() !== 8'b0000_0100) begin
            miscompares++;
            $display("[TB] FAIL stand_d3: got %b expected %b", obs(), 8'b0000_0100);
        end
        dscore = 4'd9;
        tick();
        vectors++;
        if (obs() !== 8'b0000_0001) begin
            miscompares++;
            $display("[TB] FAIL stand_done: got %b expected %b", obs(), 8'b0000_0001);
        end
    endtask

    task automatic test_banker_sweep();
        logic [3:0] d_tab [10] = '{4'd3, 4'd6, 4'd4,  4'd7, 4'd5, 4'd5, 4'd2, 4'd6, 4'd4, 4'd0};
        logic [3:0] c_tab [10] = '{4'd8, 4'd6, 4'd12, 4'd6, 4'd4, 4'd3, 4'd8, 4'd5, 4'd2, 4'd10};
        logic       w_tab [10] = '{1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] lights;
        for (int r = 0; r < 10; r++) begin
            start_round();
            for (int i = 0; i < 4; i++) tick();
            pscore = 4'd3;
            dscore = d_tab[r];
            pcard3 = 4'd0;
            tick();
            tick();
            vectors++;
            if (obs() !== 8'b0000_1000) begin
                miscompares++;
                $display("[TB] FAIL sweep%0d_p3: got %b expected %b", r, obs(), 8'b0000_1000);
            end
            pcard3 = c_tab[r];
            tick();
            vectors++;
            if (obs() !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL sweep%0d_bchk: got %b expected %b", r, obs(), 8'h00);
            end
            lights = {6'b0, (pscore >= dscore), (dscore >= pscore)};
            tick();
            vectors++;
            if (obs() !== (w_tab[r] ? 8'b0000_0100 : lights)) begin
                miscompares++;
                $display("[TB] FAIL sweep%0d_decide d=%0d c=%0d: got %b expected %b", r, d_tab[r], c_tab[r],
                         obs(), (w_tab[r] ? 8'b0000_0100 : lights));
            end
            if (w_tab[r]) begin
                tick();
                vectors++;
                if (obs() !== lights) begin
                    miscompares++;
                    $display("[TB] FAIL sweep%0d_done: got %b expected %b", r, obs(), lights);
                end
            end
        end
    endtask

    task automatic test_tie_and_reset();
        start_round();
        for (int i = 0; i < 4; i++) tick();
        pscore = 4'd6;
        dscore = 4'd6;
        tick();
        tick();
        vectors++;
        if (obs() !== 8'b0000_0011) begin
            miscompares++;
            $display("[TB] FAIL tie_66: got %b expected %b", obs(), 8'b0000_0011);
        end
        pscore = 4'd5;
        dscore = 4'd5;
        #1;
        vectors++;
        if (obs() !== 8'b0000_0011) begin
            miscompares++;
            $display("[TB] FAIL tie_55: got %b expected %b", obs(), 8'b0000_0011);
        end
        start_round();
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs() !== deal_pattern(i)) begin
                miscompares++;
                $display("[TB] FAIL midreset_deal%0d: got %b expected %b", i, obs(), deal_pattern(i));
            end
        end
        resetb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs() !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL midreset_idle%0d: got %b expected %b", i, obs(), 8'h00);
            end
        end
        resetb = 1'b0;
    endtask

`ifdef ROUND_TALLY_EN
    task automatic run_round(input logic [3:0] p, input logic [3:0] d);
        start_round();
        for (int i = 0; i < 4; i++) tick();
        pscore = p;
        dscore = d;
        tick();
        tick();
        tick();
    endtask

    task automatic test_tally();
        tally_clr = 1'b1;
        tick();
        tally_clr = 1'b0;
        vectors++;
        if ({player_wins, dealer_wins, ties} !== 24'h000000) begin
            miscompares++;
            $display("[TB] FAIL tally_init: got %h expected %h", {player_wins, dealer_wins, ties}, 24'h000000);
        end
        run_round(4'd9, 4'd3);
        run_round(4'd2, 4'd8);
        run_round(4'd7, 4'd7);
        tick();
        tick();
        vectors++;
        if ({player_wins, dealer_wins, ties} !== 24'h010101) begin
            miscompares++;
            $display("[TB] FAIL tally_three: got %h expected %h", {player_wins, dealer_wins, ties}, 24'h010101);
        end
        for (int r = 0; r < 256; r++) run_round(4'd9, 4'd0);
        vectors++;
        if ({player_wins, dealer_wins, ties} !== 24'hFF0101) begin
            miscompares++;
            $display("[TB] FAIL tally_saturate: got %h expected %h", {player_wins, dealer_wins, ties}, 24'hFF0101);
        end
        tally_clr = 1'b1;
        tick();
        tally_clr = 1'b0;
        vectors++;
        if ({player_wins, dealer_wins, ties} !== 24'h000000) begin
            miscompares++;
            $display("[TB] FAIL tally_clear: got %h expected %h", {player_wins, dealer_wins, ties}, 24'h000000);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetb      = 1'b1;
        pscore      = 4'd0;
        dscore      = 4'd0;
        pcard3      = 4'd0;
`ifdef ROUND_TALLY_EN
        tally_clr   = 1'b0;
`endif
        test_reset();
        test_natural();
        test_player_stand();
        test_banker_sweep();
        test_tie_and_reset();
`ifdef ROUND_TALLY_EN
        test_tally();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
